decode_stage_pipe: RTL



---
 rtl/decode_stage_pipe.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/decode_stage_pipe.sv
// Instruction-decode stage with an integrated ID/EX pipeline register.
// Reads a write-first register file, assembles two-word (opcode + immediate)
// instructions, stalls fetch on load-use hazards and honours flush from branch
// resolution. The EX bundle is tagged with ex_valid; bubbles zero every field.
module decode_stage_pipe #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned INSTR_W = 16,
  parameter int unsigned PC_W    = 32,
  parameter int unsigned N_REGS  = 8,
  parameter int unsigned CTRL_W  = 32,
  parameter int unsigned RS1_LSB = 8,
  parameter int unsigned RS2_LSB = 5,
  localparam int unsigned AW     = (N_REGS > 1) ? $clog2(N_REGS) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic [INSTR_W-1:0] instruction,
  input  logic [PC_W-1:0]   pc,
  input  logic [CTRL_W-1:0] ctrl_bundle,
  input  logic              ctrl_uses_rs1,
  input  logic              ctrl_uses_rs2,
  input  logic              ctrl_two_word,
  input  logic              ctrl_mem_read,
  input  logic              flush,
  input  logic              wb_we,
  input  logic [AW-1:0]     wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              stall_out,
  output logic              ex_valid,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic              ex_mem_read,
  output logic [DATA_W-1:0] ex_rdata1,
  output logic [DATA_W-1:0] ex_rdata2,
  output logic [DATA_W-1:0] ex_imm,
  output logic [PC_W-1:0]   ex_pc,
  output logic [AW-1:0]     ex_rd,
  output logic [AW-1:0]     ex_rs1,
  output logic [AW-1:0]     ex_rs2,
  output logic [3:0]        ex_shamt
);

  typedef enum logic [0:0] {StOp, StImm} state_e;

  state_e              state_q;
  logic [DATA_W-1:0]   rf_q [N_REGS];

  // Only the parts of the opcode word that EX needs are held across the gap.
  logic [PC_W-1:0]     hold_pc_q;
  logic [CTRL_W-1:0]   hold_ctrl_q;
  logic                hold_mem_read_q;
  logic [AW-1:0]       hold_rs1_q;
  logic [AW-1:0]       hold_rs2_q;
  logic [3:0]          hold_shamt_q;

  logic [AW-1:0]       in_rs1;
  logic [AW-1:0]       in_rs2;
  logic [AW-1:0]       rd_addr1;
  logic [AW-1:0]       rd_addr2;
  logic [DATA_W-1:0]   rdata1;
  logic [DATA_W-1:0]   rdata2;
  logic [DATA_W-1:0]   imm_sext;
  logic                load_use;

  assign in_rs1   = instruction[RS1_LSB +: AW];
  assign in_rs2   = instruction[RS2_LSB +: AW];
  assign imm_sext = DATA_W'($signed(instruction));

  // Operand read: latched fields while waiting for the immediate, so a
  // writeback landing in the gap is still observed; write-first forwarding.
  always_comb begin
    rd_addr1 = (state_q == StImm) ? hold_rs1_q : in_rs1;
    rd_addr2 = (state_q == StImm) ? hold_rs2_q : in_rs2;
    rdata1   = (wb_we && (wb_addr == rd_addr1)) ? wb_data : rf_q[rd_addr1];
    rdata2   = (wb_we && (wb_addr == rd_addr2)) ? wb_data : rf_q[rd_addr2];
  end

  // Load-use hazard against the load currently in EX; first words of
  // two-word ops never stall because EX holds a bubble when they complete.
  assign load_use = (state_q == StOp) && in_valid && !ctrl_two_word &&
                    ex_valid && ex_mem_read &&
                    ((ctrl_uses_rs1 && (in_rs1 == ex_rd)) ||
                     (ctrl_uses_rs2 && (in_rs2 == ex_rd)));

  assign stall_out = load_use && !flush && !reset;

  // Register file: cleared on reset, written on every clock when wb_we.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < N_REGS; i++) begin
        rf_q[i] <= '0;
      end
    end else if (wb_we) begin
      rf_q[wb_addr] <= wb_data;
    end
  end

  // Decode FSM, two-word hold register and ID/EX pipeline register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= StOp;
      hold_pc_q       <= '0;
      hold_ctrl_q     <= '0;
      hold_mem_read_q <= 1'b0;
      hold_rs1_q      <= '0;
      hold_rs2_q      <= '0;
      hold_shamt_q    <= '0;
      ex_valid        <= 1'b0;
      ex_ctrl         <= '0;
      ex_mem_read     <= 1'b0;
      ex_rdata1       <= '0;
      ex_rdata2       <= '0;
      ex_imm          <= '0;
      ex_pc           <= '0;
      ex_rd           <= '0;
      ex_rs1          <= '0;
      ex_rs2          <= '0;
      ex_shamt        <= '0;
    end else begin
      // Bubble unless a complete instruction issues below.
      ex_valid    <= 1'b0;
      ex_ctrl     <= '0;
      ex_mem_read <= 1'b0;
      ex_rdata1   <= '0;
      ex_rdata2   <= '0;
      ex_imm      <= '0;
      ex_pc       <= '0;
      ex_rd       <= '0;
      ex_rs1      <= '0;
      ex_rs2      <= '0;
      ex_shamt    <= '0;
      if (flush) begin
        state_q         <= StOp;
        hold_pc_q       <= '0;
        hold_ctrl_q     <= '0;
        hold_mem_read_q <= 1'b0;
        hold_rs1_q      <= '0;
        hold_rs2_q      <= '0;
        hold_shamt_q    <= '0;
      end else begin
        unique case (state_q)
          StOp: begin
            if (in_valid && !load_use) begin
              if (ctrl_two_word) begin
                hold_pc_q       <= pc;
                hold_ctrl_q     <= ctrl_bundle;
                hold_mem_read_q <= ctrl_mem_read;
                hold_rs1_q      <= in_rs1;
                hold_rs2_q      <= in_rs2;
                hold_shamt_q    <= instruction[3:0];
                state_q         <= StImm;
              end else begin
                ex_valid    <= 1'b1;
                ex_ctrl     <= ctrl_bundle;
                ex_mem_read <= ctrl_mem_read;
                ex_rdata1   <= rdata1;
                ex_rdata2   <= rdata2;
                ex_pc       <= pc;
                ex_rd       <= in_rs1;
                ex_rs1      <= in_rs1;
                ex_rs2      <= in_rs2;
                ex_shamt    <= instruction[3:0];
              end
            end
          end
          StImm: begin
            if (in_valid) begin
              ex_valid    <= 1'b1;
              ex_ctrl     <= hold_ctrl_q;
              ex_mem_read <= hold_mem_read_q;
              ex_rdata1   <= rdata1;
              ex_rdata2   <= rdata2;
              ex_imm      <= imm_sext;
              ex_pc       <= hold_pc_q;
              ex_rd       <= hold_rs1_q;
              ex_rs1      <= hold_rs1_q;
              ex_rs2      <= hold_rs2_q;
              ex_shamt    <= hold_shamt_q;
              state_q     <= StOp;
            end
          end
          default: state_q <= StOp;
        endcase
      end
    end
  end

endmodule
